l2r_controller: RTL and testbench

Control FSM for the left-to-right square-and-multiply exponentiation datapath. It sits directly upstream of that datapath and drives all of its load, shift, select and counter strobes. It consumes the datapath's `equals` and `regBk` status bits. It gives the system a start/busy/done handshake, so `C = A^B` (truncated to 2k bits) is computed without software sequencing.

---
 rtl/l2r_controller.sv | 153 +++++++++++++++
 tb/tb_l2r_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2r_controller.sv
// l2r_controller
// Control FSM for a left-to-right square-and-multiply exponentiation datapath.
// It drives the load, shift, select and counter strobes of the datapath and
// offers a start/busy/done handshake. The exponent is walked MSB first for
// exactly k iterations. Every output is a pure decode of the registered state.

module l2r_controller #(
   parameter int k = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       equals,
   input  logic       regBk,
   output logic       LoadA,
   output logic       LoadB,
   output logic       ShiftB,
   output logic       LoadC,
   output logic [1:0] S_C,
   output logic       LoadCoun,
   output logic       S_Coun,
   output logic       busy,
   output logic       done,
   output logic [2:0] state_dbg
);

   // The datapath owns the iteration counter; k only has to be sane here.
   if (k < 1) begin : g_bad_k
      $error("l2r_controller: k must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DEC   = 3'd2,
      S_CHECK = 3'd3,
      S_SQR   = 3'd4,
      S_MUL   = 3'd5,
      S_SHIFT = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   // Result mux codes; 2'b11 is illegal and never produced.
   localparam logic [1:0] SC_ONE = 2'b00;
   localparam logic [1:0] SC_SQR = 2'b01;
   localparam logic [1:0] SC_MUL = 2'b10;

   // Counter source codes.
   localparam logic CNT_INIT = 1'b0;   // counter <= k+1
   localparam logic CNT_DEC  = 1'b1;   // counter <= counter - 1

   state_t r_state;
   state_t w_next;

   // State register with synchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values; the reset is tested inside the clocked block
   // because it is synchronous.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: the sequence walk, with abort forcing IDLE last.
   // NOTE: w_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = S_DEC;
         S_DEC:   w_next = S_CHECK;
         S_CHECK: w_next = equals ? S_DONE : S_SQR;
         S_SQR:   w_next = regBk ? S_MUL : S_SHIFT;
         S_MUL:   w_next = S_SHIFT;
         S_SHIFT: w_next = S_CHECK;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      // Abort wins over start and over every in-flight step.
      if (abort) begin
         w_next = S_IDLE;
      end
   end

   // Moore output decode: strobes depend on the registered state only.
   always_comb begin
      LoadA    = 1'b0;
      LoadB    = 1'b0;
      ShiftB   = 1'b0;
      LoadC    = 1'b0;
      S_C      = SC_ONE;
      LoadCoun = 1'b0;
      S_Coun   = CNT_INIT;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_LOAD: begin
            // Capture operands, seed C with 1 and the counter with k+1.
            LoadA    = 1'b1;
            LoadB    = 1'b1;
            LoadC    = 1'b1;
            S_C      = SC_ONE;
            LoadCoun = 1'b1;
            S_Coun   = CNT_INIT;
            busy     = 1'b1;
         end
         S_DEC: begin
            // Bring the counter from k+1 down to k iterations remaining.
            LoadCoun = 1'b1;
            S_Coun   = CNT_DEC;
            busy     = 1'b1;
         end
         S_CHECK: begin
            busy = 1'b1;
         end
         S_SQR: begin
            LoadC = 1'b1;
            S_C   = SC_SQR;
            busy  = 1'b1;
         end
         S_MUL: begin
            LoadC = 1'b1;
            S_C   = SC_MUL;
            busy  = 1'b1;
         end
         S_SHIFT: begin
            // Expose the next exponent bit and count one iteration off.
            ShiftB   = 1'b1;
            LoadCoun = 1'b1;
            S_Coun   = CNT_DEC;
            busy     = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
            busy = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign state_dbg = r_state;

endmodule

// File: tb/tb_l2r_controller.sv
// tb_l2r_controller
// Bench for l2r_controller with a behavioural square-and-multiply datapath.
// Stimulus pushes expected results into a scoreboard queue; a monitor pops
// and compares whenever the controller pulses done.

module tb_l2r_controller;

   localparam int K = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       equals;
   logic       regBk;
   logic       LoadA, LoadB, ShiftB, LoadC, LoadCoun, S_Coun, busy, done;
   logic [1:0] S_C;
   logic [2:0] state_dbg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Datapath model
   logic [K-1:0]   in_a = '0;
   logic [K-1:0]   in_b = '0;
   logic [K-1:0]   reg_a = '0;
   logic [K-1:0]   reg_b = '0;
   logic [2*K-1:0] reg_c = '0;
   logic [5:0]     coun = '0;

   typedef struct {
      logic [2*K-1:0] c;
      int             lat;
      int             muls;
      int             shifts;
   } exp_t;

   exp_t sb[$];

   l2r_controller #(.k(K)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .equals   (equals),
      .regBk    (regBk),
      .LoadA    (LoadA),
      .LoadB    (LoadB),
      .ShiftB   (ShiftB),
      .LoadC    (LoadC),
      .S_C      (S_C),
      .LoadCoun (LoadCoun),
      .S_Coun   (S_Coun),
      .busy     (busy),
      .done     (done),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign equals = (coun == '0);
   assign regBk  = reg_b[K-1];

   always @(posedge clk) begin
      if (LoadA) reg_a <= in_a;
      if (LoadB) reg_b <= in_b;
      else if (ShiftB) reg_b <= reg_b << 1;
      if (LoadC) begin
         case (S_C)
            2'b00:   reg_c <= 1;
            2'b01:   reg_c <= reg_c * reg_c;
            2'b10:   reg_c <= reg_c * {{K{1'b0}}, reg_a};
            default: reg_c <= 'x;
         endcase
      end
      if (LoadCoun) coun <= S_Coun ? coun - 6'd1 : 6'(K + 1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, req);
      end
   endtask

   // Monitor: per-run statistics and scoreboard pop on done.
   int load_cyc = 0;
   int mul_cnt  = 0;
   int sh_cnt   = 0;
   always @(negedge clk) begin
      if (rst) begin
         if (state_dbg == 3'd1) begin
            load_cyc = cyc;
            mul_cnt  = 0;
            sh_cnt   = 0;
         end
         if (state_dbg == 3'd5) mul_cnt++;
         if (ShiftB) sh_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result_c", 64'(reg_c), 64'(e.c));
               check("latency", 64'(cyc - load_cyc + 1), 64'(e.lat));
               check("mul_visits", 64'(mul_cnt), 64'(e.muls));
               check("shift_pulses", 64'(sh_cnt), 64'(e.shifts));
               check("busy_in_done", 64'(busy), 64'd1);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2*K-1:0] c, input int lat, input int muls);
      exp_t e;
      e.c = c; e.lat = lat; e.muls = muls; e.shifts = K;
      sb.push_back(e);
   endtask

   // Issue a one-cycle start; returns just after edge 0.
   task automatic go(input logic [K-1:0] a, input logic [K-1:0] b);
      in_a = a; in_b = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Bounded wait for done, then step into IDLE.
   task automatic wait_done(input string name);
      for (int i = 0; i < 200; i++) begin
         if (done) break;
         tick();
      end
      if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
      tick();
   endtask

   function automatic logic [12:0] outs();
      return {LoadA, LoadB, ShiftB, LoadC, S_C, LoadCoun, S_Coun, busy, done, state_dbg};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with start high: everything stays quiet.
      rst = 1'b0; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_outputs", 64'(outs()), 64'd0);
      end
      in_a = 16'd3; in_b = 16'd5;
      push(32'd243, 54, 2);
      rst = 1'b1;
      tick();
      check("load_after_reset", 64'(state_dbg), 64'd1);
      check("busy_in_load", 64'(busy), 64'd1);
      start = 1'b0;
      wait_done("a3_b5");
      check("idle_after_done", 64'(state_dbg), 64'd0);
      check("busy_low_idle", 64'(busy), 64'd0);

      // Zero exponent and all-ones exponent.
      push(32'd1, 52, 0);
      go(16'd7, 16'd0);
      wait_done("a7_b0");
      push(32'd1, 68, 16);
      go(16'd1, 16'hFFFF);
      wait_done("a1_bffff");

      // Stray start pulses mid-run are ignored.
      push(32'd125, 54, 2);
      go(16'd5, 16'd3);
      repeat (4) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (14) tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_done("start_ignored");

      // Abort in cycle 10 with start also high: back to IDLE, no done.
      go(16'd9, 16'd9);
      repeat (10) tick();
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      check("abort_idle", 64'(state_dbg), 64'd0);
      check("abort_no_done", 64'(done), 64'd0);
      tick();
      check("abort_stays_idle", 64'(state_dbg), 64'd0);
      push(32'd1024, 54, 2);
      go(16'd2, 16'd10);
      wait_done("a2_b10");

      // Start held high: back-to-back runs with one IDLE cycle between.
      push(32'd2, 53, 1);
      push(32'd2, 53, 1);
      in_a = 16'd2; in_b = 16'd1;
      start = 1'b1;
      tick();
      wait_done("b2b_first");
      check("b2b_idle_gap", 64'(state_dbg), 64'd0);
      tick();
      check("b2b_reload", 64'(state_dbg), 64'd1);
      start = 1'b0;
      wait_done("b2b_second");

      // Reset during a MUL cycle: strobes drop at the next edge.
      go(16'd3, 16'd7);
      for (int i = 0; i < 100; i++) begin
         if (state_dbg == 3'd5) break;
         tick();
      end
      check("reached_mul", 64'(state_dbg), 64'd5);
      rst = 1'b0;
      tick();
      check("midrun_reset_outputs", 64'(outs()), 64'd0);
      rst = 1'b1;
      tick();
      check("post_reset_idle", 64'(outs()), 64'd0);
      push(32'h8000_0000, 57, 5);
      go(16'd2, 16'd31);
      wait_done("a2_b31");

      repeat (3) tick();
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
